// File: rtl/sha3_pkg.sv
// sha3_pkg: shared types and helpers for the SHA3 sponge controller.
//   mode_e        SHA3 digest length selector (224/256/384/512)
//   ctrl_state_e  sponge controller FSM states
//   rate_lanes()  number of 64-bit lanes absorbed per block for a mode
//   PAD_FIRST     domain-separation byte XORed into the first free lane
//   PAD_LAST      final padding bit XORed into the last rate lane
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_SHA3_224 = 2'd0,
        MODE_SHA3_256 = 2'd1,
        MODE_SHA3_384 = 2'd2,
        MODE_SHA3_512 = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ABSORB    = 3'd1,
        PAD       = 3'd2,
        PERM      = 3'd3,
        WAIT_PERM = 3'd4,
        DONE      = 3'd5
    } ctrl_state_e;

    localparam logic [63:0] PAD_FIRST = 64'h0000_0000_0000_0006;
    localparam logic [63:0] PAD_LAST  = 64'h8000_0000_0000_0000;

    function automatic logic [4:0] rate_lanes(input mode_e m);
        case (m)
            MODE_SHA3_224: rate_lanes = 5'd18;
            MODE_SHA3_256: rate_lanes = 5'd17;
            MODE_SHA3_384: rate_lanes = 5'd13;
            MODE_SHA3_512: rate_lanes = 5'd9;
            default:       rate_lanes = 5'd17;
        endcase
    endfunction

endpackage

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: sequences the SHA3 sponge around an external 25x64-bit
// lane state register and an external Keccak-f permutation core.
//
// Ports:
//   ACLK, ARESETn        clock (rising edge), asynchronous active-low reset
//   mode[1:0]            SHA3 variant, sampled on the first beat of a message
//   s_tdata/s_tvalid/s_tlast/s_tready   AXI-Stream message input, one lane per beat
//   state_clr            one-cycle pulse clearing the state register
//   lane_we/lane_idx/lane_data          XOR write into lane lane_idx
//   perm_start           one-cycle pulse starting the permutation
//   perm_done            one-cycle completion pulse from the permutation core
//   digest_valid/digest_ready           digest handshake
//   busy                 controller not IDLE
//   err                  sticky permutation timeout flag
//   perm_count/msg_count statistics (only with SHA3_CTRL_STATS_EN defined)
//
// Parameters:
//   DATA_WIDTH    lane width, must be 64
//   PERM_TIMEOUT  cycles allowed in WAIT_PERM before err sets, 0 = no timeout
//
// Build option: define SHA3_CTRL_STATS_EN to add the perm_count/msg_count
// statistics outputs.
//
// state_clr is issued in the same cycle as the lane 0 write of a new message;
// the state register must apply the clear before the XOR write.
module sha3_sponge_ctrl
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int PERM_TIMEOUT = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  state_clr,
    output logic                  lane_we,
    output logic [4:0]            lane_idx,
    output logic [63:0]           lane_data,
    output logic                  perm_start,
    input  logic                  perm_done,
    output logic                  digest_valid,
    input  logic                  digest_ready,
    output logic                  busy,
`ifdef SHA3_CTRL_STATS_EN
    output logic [31:0]           perm_count,
    output logic [31:0]           msg_count,
`endif
    output logic                  err
);

    generate
        if (DATA_WIDTH != 64) begin : g_bad_width
            $error("sha3_sponge_ctrl: DATA_WIDTH must be 64");
        end
    endgenerate

    localparam logic [31:0] TMO_LIMIT = 32'(PERM_TIMEOUT);

    ctrl_state_e state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [4:0]  count_q, count_d;
    logic        last_q, last_d;
    logic        pad_pending_q, pad_pending_d;
    logic        pad_second_q, pad_second_d;   // first pad lane done, rate-1 lane still owed
    logic [31:0] tmo_q, tmo_d;

    logic        s_tready_q, s_tready_d;
    logic        state_clr_q, state_clr_d;
    logic        lane_we_q, lane_we_d;
    logic [4:0]  lane_idx_q, lane_idx_d;
    logic [63:0] lane_data_q, lane_data_d;
    logic        perm_start_q, perm_start_d;
    logic        digest_valid_q, digest_valid_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
`ifdef SHA3_CTRL_STATS_EN
    logic [31:0] perm_count_q, perm_count_d;
    logic [31:0] msg_count_q, msg_count_d;
`endif

    mode_e      cur_mode;
    logic [4:0] rate;
    logic       hs;
    logic [4:0] cnt_base;
    logic [4:0] cnt_next;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        count_d        = count_q;
        last_d         = last_q;
        pad_pending_d  = pad_pending_q;
        pad_second_d   = pad_second_q;
        tmo_d          = tmo_q;
        state_clr_d    = 1'b0;
        lane_we_d      = 1'b0;
        lane_idx_d     = lane_idx_q;
        lane_data_d    = lane_data_q;
        perm_start_d   = 1'b0;
        digest_valid_d = digest_valid_q;
        err_d          = err_q;
`ifdef SHA3_CTRL_STATS_EN
        perm_count_d   = perm_count_q;
        msg_count_d    = msg_count_q;
`endif

        // In IDLE the incoming mode governs the first beat; afterwards the latched one.
        cur_mode = (state_q == IDLE) ? mode_e'(mode) : mode_q;
        rate     = rate_lanes(cur_mode);
        hs       = s_tvalid && s_tready_q;
        cnt_base = (state_q == IDLE) ? 5'd0 : count_q;
        cnt_next = cnt_base + 5'd1;

        case (state_q)
            IDLE, ABSORB: begin
                if (hs) begin
                    if (state_q == IDLE) begin
                        mode_d        = mode_e'(mode);
                        state_clr_d   = 1'b1;
                        last_d        = 1'b0;
                        pad_pending_d = 1'b0;
                    end
                    lane_we_d   = 1'b1;
                    lane_idx_d  = cnt_base;
                    lane_data_d = s_tdata;
                    count_d     = cnt_next;
                    if (cnt_next == rate) begin
                        state_d       = PERM;
                        pad_pending_d = s_tlast;
                    end else if (s_tlast) begin
                        state_d      = PAD;
                        pad_second_d = 1'b0;
                    end else begin
                        state_d = ABSORB;
                    end
                end
            end

            PAD: begin
                lane_we_d = 1'b1;
                if (!pad_second_q) begin
                    lane_idx_d = count_q;
                    if (count_q == rate - 5'd1) begin
                        // Both padding bits land in the same lane.
                        lane_data_d = PAD_LAST | PAD_FIRST;
                        last_d      = 1'b1;
                        state_d     = PERM;
                    end else begin
                        lane_data_d  = PAD_FIRST;
                        pad_second_d = 1'b1;
                    end
                end else begin
                    lane_idx_d   = rate - 5'd1;
                    lane_data_d  = PAD_LAST;
                    pad_second_d = 1'b0;
                    last_d       = 1'b1;
                    state_d      = PERM;
                end
            end

            PERM: begin
                perm_start_d = 1'b1;
                tmo_d        = 32'd0;
                state_d      = WAIT_PERM;
`ifdef SHA3_CTRL_STATS_EN
                perm_count_d = perm_count_q + 32'd1;
`endif
            end

            WAIT_PERM: begin
                if (perm_done) begin
                    if (last_q) begin
                        digest_valid_d = 1'b1;
                        state_d        = DONE;
                    end else if (pad_pending_q) begin
                        // Message ended exactly on a block boundary: pad a fresh block.
                        count_d       = 5'd0;
                        pad_pending_d = 1'b0;
                        pad_second_d  = 1'b0;
                        state_d       = PAD;
                    end else begin
                        count_d = 5'd0;
                        state_d = ABSORB;
                    end
                end else if (TMO_LIMIT != 32'd0) begin
                    if (tmo_q + 32'd1 >= TMO_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
                end
            end

            DONE: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    state_d        = IDLE;
`ifdef SHA3_CTRL_STATS_EN
                    msg_count_d    = msg_count_q + 32'd1;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that the flags line up with the state they describe.
        s_tready_d = (state_d == IDLE) || (state_d == ABSORB);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q        <= IDLE;
            mode_q         <= MODE_SHA3_256;
            count_q        <= 5'd0;
            last_q         <= 1'b0;
            pad_pending_q  <= 1'b0;
            pad_second_q   <= 1'b0;
            tmo_q          <= 32'd0;
            s_tready_q     <= 1'b0;
            state_clr_q    <= 1'b0;
            lane_we_q      <= 1'b0;
            lane_idx_q     <= 5'd0;
            lane_data_q    <= 64'd0;
            perm_start_q   <= 1'b0;
            digest_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
`ifdef SHA3_CTRL_STATS_EN
            perm_count_q   <= 32'd0;
            msg_count_q    <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            count_q        <= count_d;
            last_q         <= last_d;
            pad_pending_q  <= pad_pending_d;
            pad_second_q   <= pad_second_d;
            tmo_q          <= tmo_d;
            s_tready_q     <= s_tready_d;
            state_clr_q    <= state_clr_d;
            lane_we_q      <= lane_we_d;
            lane_idx_q     <= lane_idx_d;
            lane_data_q    <= lane_data_d;
            perm_start_q   <= perm_start_d;
            digest_valid_q <= digest_valid_d;
            busy_q         <= busy_d;
            err_q          <= err_d;
`ifdef SHA3_CTRL_STATS_EN
            perm_count_q   <= perm_count_d;
            msg_count_q    <= msg_count_d;
`endif
        end
    end

    assign s_tready     = s_tready_q;
    assign state_clr    = state_clr_q;
    assign lane_we      = lane_we_q;
    assign lane_idx     = lane_idx_q;
    assign lane_data    = lane_data_q;
    assign perm_start   = perm_start_q;
    assign digest_valid = digest_valid_q;
    assign busy         = busy_q;
    assign err          = err_q;
`ifdef SHA3_CTRL_STATS_EN
    assign perm_count   = perm_count_q;
    assign msg_count    = msg_count_q;
`endif

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// tb_sha3_sponge_ctrl: scoreboard bench for sha3_sponge_ctrl.
// Expected lane writes are queued as beats are driven and popped as the DUT
// issues them; a small permutation-core model answers perm_start after a
// fixed latency.
module tb_sha3_sponge_ctrl;

    localparam int          PERM_LAT = 3;
    localparam logic [63:0] P_FIRST  = 64'h0000_0000_0000_0006;
    localparam logic [63:0] P_LAST   = 64'h8000_0000_0000_0000;

    logic        ACLK;
    logic        ARESETn;
    logic [1:0]  mode;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        state_clr;
    logic        lane_we;
    logic [4:0]  lane_idx;
    logic [63:0] lane_data;
    logic        perm_start;
    logic        perm_done;
    logic        digest_valid;
    logic        digest_ready;
    logic        busy;
    logic        err;
`ifdef SHA3_CTRL_STATS_EN
    logic [31:0] perm_count;
    logic [31:0] msg_count;
`endif

    sha3_sponge_ctrl #(.DATA_WIDTH(64), .PERM_TIMEOUT(10)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .mode         (mode),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .state_clr    (state_clr),
        .lane_we      (lane_we),
        .lane_idx     (lane_idx),
        .lane_data    (lane_data),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy),
`ifdef SHA3_CTRL_STATS_EN
        .perm_count   (perm_count),
        .msg_count    (msg_count),
`endif
        .err          (err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  wcyc[$];
    int  pcyc[$];
    int  ccyc[$];
    int  cyc    = 0;
    int  dcyc   = -1;
    int  dvcyc  = -1;
    int  errcyc = -1;
    bit  in_wait  = 0;
    bit  prev_dv  = 0;
    bit  prev_err = 0;

    // Permutation core model, plus a hook for a stray perm_done pulse.
    bit  hold_perm  = 0;
    bit  stray_done = 0;
    bit  model_done = 0;
    int  pend       = 0;
    assign perm_done = model_done | stray_done;

    always @(negedge ACLK) begin
        model_done = 1'b0;
        if (!ARESETn) begin
            pend = 0;
        end else if (perm_start && !hold_perm) begin
            pend = PERM_LAT;
        end else if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) model_done = 1'b1;
        end
    end

    // Output monitor, sampled 2 ns after each rising edge.
    always @(posedge ACLK) begin
        wr_t e;
        #2;
        cyc++;
        if (!ARESETn) begin
            in_wait  = 0;
            prev_dv  = 0;
            prev_err = 0;
        end else begin
            if (lane_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {59'd0, lane_idx}, 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("lane_idx", {59'd0, lane_idx}, {59'd0, e.idx});
                    chk("lane_data", lane_data, e.data);
                end
                wcyc.push_back(cyc);
            end
            if (state_clr) ccyc.push_back(cyc);
            if (perm_start) begin
                pcyc.push_back(cyc);
                in_wait = 1;
            end
            if (perm_done) begin
                in_wait = 0;
                dcyc    = cyc;
            end
            if (in_wait) chk("tready_in_wait", {63'd0, s_tready}, 64'd0);
            if (digest_valid && !prev_dv) dvcyc = cyc;
            prev_dv = digest_valid;
            if (err && !prev_err) errcyc = cyc;
            prev_err = err;
        end
    end

    function automatic int tb_rate(input logic [1:0] m);
        case (m)
            2'd0: return 18;
            2'd1: return 17;
            2'd2: return 13;
            default: return 9;
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_beat(input logic [63:0] d, input logic last);
        int w;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = last;
        w = 0;
        while (!s_tready && w < 200) begin
            @(negedge ACLK);
            w++;
        end
        if (!s_tready) begin
            chk("tready_timeout", 64'd0, 64'd1);
        end else begin
            @(posedge ACLK);
            @(negedge ACLK);
        end
    endtask

    task automatic run_msg(input logic [1:0] m, input int n, input logic [63:0] base,
                           input bit finish_digest);
        int   r;
        int   k;
        int   w;
        wr_t  e;
        logic [63:0] d;
        r = tb_rate(m);
        wcyc.delete();
        pcyc.delete();
        ccyc.delete();
        dvcyc = -1;
        mode  = m;
        for (int i = 0; i < n; i++) begin
            d = base ^ (64'(i) * 64'h0101_0101_0101_0101);
            e.idx  = 5'(i % r);
            e.data = d;
            exp_q.push_back(e);
            if (i == n - 1) begin
                k = n % r;
                if (k == r - 1) begin
                    e.idx = 5'(k); e.data = P_LAST | P_FIRST; exp_q.push_back(e);
                end else begin
                    e.idx = 5'(k);     e.data = P_FIRST; exp_q.push_back(e);
                    e.idx = 5'(r - 1); e.data = P_LAST;  exp_q.push_back(e);
                end
            end
            send_beat(d, i == n - 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        if (finish_digest) begin
            w = 0;
            while (!digest_valid && w < 500) begin
                @(negedge ACLK);
                w++;
            end
            chk("digest_valid_seen", {63'd0, digest_valid}, 64'd1);
            chk("writes_all_done", 64'(exp_q.size()), 64'd0);
            chk("perm_start_count", 64'(pcyc.size()), 64'(n / r + 1));
            chk("state_clr_count", 64'(ccyc.size()), 64'd1);
            chk("digest_after_last_done", 64'(dvcyc), 64'(dcyc));
            repeat (2) @(negedge ACLK);
            chk("digest_held", {63'd0, digest_valid}, 64'd1);
            digest_ready = 1'b1;
            @(negedge ACLK);
            digest_ready = 1'b0;
            chk("digest_cleared", {63'd0, digest_valid}, 64'd0);
            chk("idle_after_digest", {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tready"},  {63'd0, s_tready},     64'd0);
        chk({tag, "_busy"},    {63'd0, busy},         64'd0);
        chk({tag, "_lane_we"}, {63'd0, lane_we},      64'd0);
        chk({tag, "_pstart"},  {63'd0, perm_start},   64'd0);
        chk({tag, "_dvalid"},  {63'd0, digest_valid}, 64'd0);
        chk({tag, "_clr"},     {63'd0, state_clr},    64'd0);
        chk({tag, "_err"},     {63'd0, err},          64'd0);
        chk({tag, "_idx"},     {59'd0, lane_idx},     64'd0);
        chk({tag, "_data"},    lane_data,             64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        ARESETn      = 1'b0;
        mode         = 2'd1;
        s_tdata      = 64'd0;
        s_tvalid     = 1'b0;
        s_tlast      = 1'b0;
        digest_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("idle_tready", {63'd0, s_tready}, 64'd1);

        // Single-lane "abc" message, mode 1, with latency relations.
        run_msg(2'd1, 1, 64'h0000_0000_0063_6261, 1'b1);
        chk("t1_write_count", 64'(wcyc.size()), 64'd3);
        if (wcyc.size() == 3 && pcyc.size() == 1 && ccyc.size() == 1) begin
            chk("t1_clr_with_lane0", 64'(ccyc[0]), 64'(wcyc[0]));
            chk("t1_pad1_lat", 64'(wcyc[1]), 64'(wcyc[0] + 1));
            chk("t1_pad2_lat", 64'(wcyc[2]), 64'(wcyc[0] + 2));
            chk("t1_pstart_lat", 64'(pcyc[0]), 64'(wcyc[0] + 3));
        end

        // 16 lanes: single combined pad write in lane 16.
        run_msg(2'd1, 16, 64'h1111_2222_3333_4444, 1'b1);
        chk("t2_write_count", 64'(wcyc.size()), 64'd17);

        // 17 lanes: block fills, then a whole padding block.
        run_msg(2'd1, 17, 64'hDEAD_BEEF_0000_0001, 1'b1);
        chk("t3_write_count", 64'(wcyc.size()), 64'd19);
        if (wcyc.size() == 19 && pcyc.size() == 2) begin
            chk("t3_pstart_after_lane16", 64'(pcyc[0]), 64'(wcyc[16] + 1));
            chk("t3_pstart2_after_pad", 64'(pcyc[1]), 64'(wcyc[18] + 1));
        end

        // Mode 3, 20 lanes, valid held through permutations.
        run_msg(2'd3, 20, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
        chk("t4_write_count", 64'(wcyc.size()), 64'd22);
        chk("no_err_normal", {63'd0, err}, 64'd0);

        // Reset during WAIT_PERM, then a stray perm_done.
        run_msg(2'd1, 1, 64'h0000_0000_0000_00AA, 1'b0);
        w = 0;
        while (pcyc.size() == 0 && w < 100) begin
            @(negedge ACLK);
            w++;
        end
        chk("rst_reached_wait", 64'(pcyc.size()), 64'd1);
        ARESETn = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge ACLK);
        stray_done = 1'b1;
        @(negedge ACLK);
        stray_done = 1'b0;
        repeat (5) @(negedge ACLK);
        chk("stray_no_digest", {63'd0, digest_valid}, 64'd0);
        chk("stray_idle", {63'd0, busy}, 64'd0);
        chk("stray_no_pstart", 64'(pcyc.size()), 64'd1);
        chk("stray_tready", {63'd0, s_tready}, 64'd1);

        // Next message restarts at lane 0.
        run_msg(2'd1, 2, 64'h0123_4567_89AB_CDEF, 1'b1);

        // Timeout: perm_done withheld.
        hold_perm = 1;
        errcyc    = -1;
        run_msg(2'd0, 1, 64'h0000_0000_0000_0055, 1'b0);
        w = 0;
        while (pcyc.size() == 0 && w < 100) begin
            @(negedge ACLK);
            w++;
        end
        chk("tmo_reached_wait", 64'(pcyc.size()), 64'd1);
        repeat (14) @(negedge ACLK);
        chk("tmo_err_set", {63'd0, err}, 64'd1);
        if (pcyc.size() == 1) chk("tmo_err_cycle", 64'(errcyc - pcyc[0]), 64'd10);
        chk("tmo_still_busy", {63'd0, busy}, 64'd1);
        repeat (10) @(negedge ACLK);
        chk("tmo_err_sticky", {63'd0, err}, 64'd1);
        chk("tmo_no_digest", {63'd0, digest_valid}, 64'd0);
        ARESETn = 1'b0;
        #1;
        chk("tmo_err_cleared", {63'd0, err}, 64'd0);
        @(negedge ACLK);
        ARESETn   = 1'b1;
        hold_perm = 0;
        exp_q.delete();
        repeat (3) @(negedge ACLK);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
Name: sha3_sponge_ctrl

Overview:
Sequences the SHA3 sponge around the 1600-bit lane state register and the Keccak-f permutation core.
- Accepts a 64-bit AXI-Stream message, one lane per beat.
- Issues lane-indexed XOR writes into the state and counts lanes against the mode's rate.
- Inserts SHA3 padding and starts the permutation each time a block is full or the message ends.
- Signals digest availability once the final permutation completes.

Parameters:
DATA_WIDTH, 64, stream/lane width; only 64 is supported, and elaboration fails otherwise.
PERM_TIMEOUT, 0, cycles allowed in WAIT_PERM before the err flag sets; 0 disables the timeout.

Ports:
ACLK  in  1  clock; all logic rising-edge.
ARESETn  in  1  reset, asynchronous, active-low.
mode  in  2  0=SHA3-224 (rate 18), 1=SHA3-256 (17), 2=SHA3-384 (13), 3=SHA3-512 (9); sampled on the first beat of a message.
s_tdata  in  DATA_WIDTH  message lane.
s_tvalid  in  1  beat valid.
s_tlast  in  1  last lane of the message.
s_tready  out  1  controller accepts a beat.
state_clr  out  1  one-cycle pulse; zeroes the state register.
lane_we  out  1  XOR-write strobe into the state.
lane_idx  out  5  lane index 0..24.
lane_data  out  64  value XORed into lane lane_idx.
perm_start  out  1  one-cycle pulse; starts Keccak-f.
perm_done  in  1  one-cycle pulse from the permutation core.
digest_valid  out  1  digest readable in the state register.
digest_ready  in  1  consumer has taken the digest.
busy  out  1  high whenever state != IDLE.
err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values:
  - All outputs 0, except s_tready = 0.
  - FSM in IDLE; lane counter 0; latched mode 1.
- FSM states and transitions:
  - IDLE: s_tready = 1. On the first handshake: latch mode, pulse state_clr, set lane_we for lane 0 one cycle later, go to ABSORB.
  - ABSORB: s_tready = 1 while the lane count < rate.
    - Each handshake produces, one cycle later, a registered write: lane_we = 1, lane_idx = count, lane_data = s_tdata. Count then increments.
    - Beat fills the rate (count reaches rate): drop s_tready, go to PERM. If s_tlast was also set, record pad_pending.
    - s_tlast with count < rate after increment: go to PAD.
  - PAD: write lane k = count with 0x06.
    - If k == rate-1, write 0x8000_0000_0000_0006 in a single write.
    - Otherwise, on the next cycle, write lane rate-1 with 0x8000_0000_0000_0000.
    - Lanes in between are untouched (XOR with zero). Then go to PERM with last = 1.
  - PERM: pulse perm_start exactly one cycle after the final lane write. Go to WAIT_PERM.
  - WAIT_PERM: s_tready = 0.
    - perm_done, last = 1: go to DONE.
    - perm_done, pad_pending: clear count, go to PAD (k = 0).
    - perm_done otherwise: clear count, return to ABSORB.
  - DONE: digest_valid = 1 until the cycle digest_ready = 1 is sampled, then go to IDLE. state_clr is not issued, so the digest persists until the next message.
- Boundary rules:
  - Minimum message is 1 lane; zero-length messages are unsupported.
  - perm_done outside WAIT_PERM is ignored.
  - s_tvalid with s_tready = 0 must be held by the source (AXI rule); no beat is dropped.
  - Timeout (PERM_TIMEOUT > 0): counter restarts on entry to WAIT_PERM. On expiry, err sets and the FSM stays in WAIT_PERM.
  - ARESETn low in any state aborts immediately. No partial digest_valid; the next message restarts at lane 0.
- Latency, mode 1, single lane, perm core latency P:
  - handshake → lane write +1.
  - pad writes +2, +3.
  - perm_start +4.
  - digest_valid at perm_done + 1.

Optional Feature:
SHA3_CTRL_STATS_EN
- Defined: adds output ports perm_count[31:0] and msg_count[31:0]. Each increments on perm_start and DONE exit respectively, wraps at 2^32, and resets to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- sha3_pkg:
  - mode_e enum.
  - rate_lanes(mode) function.
  - Constants PAD_FIRST = 64'h06 and PAD_LAST = 64'h8000_0000_0000_0000.
  - ctrl_state_e enum {IDLE, ABSORB, PAD, PERM, WAIT_PERM, DONE}.
- No sub-module needed. The FSM, lane counter and timeout counter live in one module.

Test Plan:
- Mode 1, one beat 0x0000_0000_0063_6261 with tlast:
  - state_clr pulse.
  - Writes: lane0 = 0x...636261, lane1 = 0x06, lane16 = 0x8000_0000_0000_0000.
  - Single perm_start, digest_valid after perm_done, cleared by digest_ready.
- Mode 1, 16 beats, tlast on 16th → single pad write, lane16 = 0x8000_0000_0000_0006, one perm_start.
- Mode 1, 17 beats, tlast on 17th:
  - First perm_start after lane16.
  - After perm_done: lane0 = 0x06, lane16 = 0x8000_0000_0000_0000, second perm_start.
  - digest_valid after the second perm_done.
- Mode 3, 20 beats with s_tvalid held during permutations:
  - s_tready = 0 throughout WAIT_PERM.
  - Blocks split at beats 9 and 18.
  - Pad at lane 2 and lane 8.
  - 3 perm_start pulses total.
- ARESETn low for 1 cycle during WAIT_PERM, stray perm_done afterward → all outputs 0, FSM stays IDLE, no digest_valid.
- PERM_TIMEOUT = 10, perm_done withheld → err = 1 on cycle 10 of WAIT_PERM and stays set until reset.
